ex_branch: RTL and testbench
============================

EX_BRANCH -- requirements
Module: ex_branch

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data/operand width.
REQ-002 SHALL have parameter ADDR_W, default 32, PC/offset/target width.
REQ-003 SHALL have parameter TAG_W, default 4, ROB tag width.
REQ-004 SHALL have parameter OP_W, default 6, op field width; encodings are the `JAL, `JALR, `BEQ, `BNE, `BLT, `BGE, `BLTU, `BGEU macros from defines.vh.
REQ-005 SHALL have parameter CNT_W, default 16, statistics counter width.
REQ-006 SHALL have clk  input  1  clock; all state changes on rising edge.
REQ-007 SHALL have rst  input  1  reset, synchronous, active-high.
REQ-008 SHALL have rdy  input  1  global enable; when low, all state holds.
REQ-009 SHALL have clear  input  1  misprediction flush, synchronous.
REQ-010 SHALL have ex_en, ex_src1[DATA_W], ex_src2[DATA_W], ex_pc[ADDR_W], ex_op[OP_W], ex_offset[ADDR_W] and ex_dest[TAG_W] as inputs carrying the issued op from the branch reservation station.
REQ-011 SHALL have cdb_grant  input  1  CDB arbiter accepts the held result this cycle.
REQ-012 SHALL have rst_en  output  1  held result valid on CDB.
REQ-013 SHALL have rst_tag  output  TAG_W  destination tag of held result.
REQ-014 SHALL have rst_data  output  DATA_W  link value of held result.
REQ-015 SHALL have jump_en  output  1  held result is taken and requires a fetch redirect.
REQ-016 SHALL have jump_target  output  ADDR_W  redirect PC.
REQ-017 SHALL have ex_busy  output  1  combinational; high means the reservation station must not issue this cycle.
REQ-018 SHALL have overflow  output  1  sticky; an issue arrived while ex_busy was high.
REQ-019 SHALL have branch_cnt  output  CNT_W  count of accepted ops.
REQ-020 SHALL have taken_cnt  output  CNT_W  count of accepted taken ops.

Function
REQ-021 SHALL implement a one-entry result buffer with states EMPTY and FULL; rst_en SHALL be high exactly when FULL.
REQ-022 ex_busy SHALL equal FULL && !cdb_grant.
REQ-023 An op is accepted when rdy && ex_en && !ex_busy && ex_op is one of the eight branch encodings; its result SHALL be FULL on the next edge (1-cycle latency).
REQ-024 ex_en with any other op SHALL be ignored: no state change, no counter change.
REQ-025 Transitions: EMPTY->FULL on accept; FULL->EMPTY on cdb_grant without accept; FULL->FULL on cdb_grant with a simultaneous accept, which loads the new result; FULL holds its contents while cdb_grant is low.
REQ-026 Taken: JAL and JALR are always taken; BEQ/BNE compare src1 and src2 for equality; BLT/BGE compare them signed; BLTU/BGEU compare them unsigned.
REQ-027 jump_target: JALR = (src1 + offset) with bit 0 cleared; all other ops = pc + offset; all sums wrap modulo 2^ADDR_W.
REQ-028 rst_data SHALL be pc + 4 (wrapping) for JAL/JALR and 0 for conditional branches; rst_tag SHALL be ex_dest unchanged.
REQ-029 jump_en SHALL be held with rst_en and be high iff the held op is taken; it SHALL be 0 when EMPTY.
REQ-030 ex_en while ex_busy is high SHALL drop the op and set overflow, which clears only on rst.
REQ-031 On accept, branch_cnt SHALL increment, and taken_cnt SHALL also increment if the op is taken; both SHALL saturate at all-ones.
REQ-032 clear SHALL force EMPTY on the next edge and discard any same-cycle accept; counters and overflow SHALL be unaffected.
REQ-033 With rdy low, state, outputs and counters SHALL hold, and cdb_grant and ex_en SHALL be ignored.

Reset
REQ-034 rst has priority over clear and rdy; on the next edge: EMPTY, rst_en=0, jump_en=0, rst_tag=0, rst_data=0, jump_target=0, overflow=0, branch_cnt=0, taken_cnt=0.
REQ-035 rst asserted while FULL SHALL discard the held result without a CDB transfer.

Verification
REQ-036 BEQ with src1=src2=5, pc=0x100, offset=0x20, dest=3 -> next cycle: rst_en=1, jump_en=1, jump_target=0x120, rst_tag=3, rst_data=0.
REQ-037 BLT with src1=0xFFFFFFFF, src2=1 -> taken; BLTU with the same operands -> jump_en=0 with rst_en=1.
REQ-038 JALR with src1=0x1001, offset=0x4, pc=0x200 -> jump_target=0x1004, rst_data=0x204.
REQ-039 FULL with cdb_grant=0 for 3 cycles -> outputs stable and ex_busy=1; ex_en pulse in that window -> overflow=1 and branch_cnt unchanged; then cdb_grant=1 together with a new ex_en -> new result on the next edge.
REQ-040 Accept together with clear -> EMPTY next edge; branch_cnt still increments only for non-cleared accepts (here unchanged).
REQ-041 0xFFFF accepts followed by one more -> branch_cnt stays at 0xFFFF; rst -> all counters return to 0.

Source files
------------

// File: rtl/ex_branch.sv
// Branch execution unit: resolves jumps/branches in one cycle and holds the
// result in a one-entry buffer until the CDB arbiter grants it.
module ex_branch #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int TAG_W  = 4,
  parameter int OP_W   = 6,
  parameter int CNT_W  = 16,
  parameter logic [OP_W-1:0] OP_JAL  = OP_W'(1),
  parameter logic [OP_W-1:0] OP_JALR = OP_W'(2),
  parameter logic [OP_W-1:0] OP_BEQ  = OP_W'(3),
  parameter logic [OP_W-1:0] OP_BNE  = OP_W'(4),
  parameter logic [OP_W-1:0] OP_BLT  = OP_W'(5),
  parameter logic [OP_W-1:0] OP_BGE  = OP_W'(6),
  parameter logic [OP_W-1:0] OP_BLTU = OP_W'(7),
  parameter logic [OP_W-1:0] OP_BGEU = OP_W'(8)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              clear,
  input  logic              ex_en,
  input  logic [DATA_W-1:0] ex_src1,
  input  logic [DATA_W-1:0] ex_src2,
  input  logic [ADDR_W-1:0] ex_pc,
  input  logic [OP_W-1:0]   ex_op,
  input  logic [ADDR_W-1:0] ex_offset,
  input  logic [TAG_W-1:0]  ex_dest,
  input  logic              cdb_grant,
  output logic              rst_en,
  output logic [TAG_W-1:0]  rst_tag,
  output logic [DATA_W-1:0] rst_data,
  output logic              jump_en,
  output logic [ADDR_W-1:0] jump_target,
  output logic              ex_busy,
  output logic              overflow,
  output logic [CNT_W-1:0]  branch_cnt,
  output logic [CNT_W-1:0]  taken_cnt
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t state, state_next;

  logic              is_branch;
  logic              accept;
  logic              load;
  logic              taken;
  logic [ADDR_W-1:0] pc_sum;
  logic [ADDR_W-1:0] reg_sum;
  logic [ADDR_W-1:0] target;
  logic [DATA_W-1:0] link;
  logic              held_taken;

  assign pc_sum  = ex_pc + ex_offset;
  assign reg_sum = ADDR_W'(ex_src1) + ex_offset;

  // Decode the op and resolve direction, target and link value in one pass.
  always_comb begin
    is_branch = 1'b1;
    taken     = 1'b0;
    link      = '0;
    target    = pc_sum;
    case (ex_op)
      OP_JAL: begin
        taken = 1'b1;
        link  = DATA_W'(ex_pc + ADDR_W'(4));
      end
      OP_JALR: begin
        taken  = 1'b1;
        link   = DATA_W'(ex_pc + ADDR_W'(4));
        target = {reg_sum[ADDR_W-1:1], 1'b0};
      end
      OP_BEQ:  taken = (ex_src1 == ex_src2);
      OP_BNE:  taken = (ex_src1 != ex_src2);
      OP_BLT:  taken = ($signed(ex_src1) <  $signed(ex_src2));
      OP_BGE:  taken = ($signed(ex_src1) >= $signed(ex_src2));
      OP_BLTU: taken = (ex_src1 <  ex_src2);
      OP_BGEU: taken = (ex_src1 >= ex_src2);
      default: is_branch = 1'b0;
    endcase
  end

  assign ex_busy = (state == FULL) && !cdb_grant;
  assign accept  = rdy && ex_en && !ex_busy && is_branch;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
    end else if (rdy) begin
      state <= state_next;
    end
  end

  // A flush wins over a same-cycle accept; a grant with an accept reloads.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    case (state)
      EMPTY: begin
        if (!clear && accept) begin
          state_next = FULL;
          load       = 1'b1;
        end
      end
      FULL: begin
        if (clear) begin
          state_next = EMPTY;
        end else if (accept) begin
          state_next = FULL;
          load       = 1'b1;
        end else if (cdb_grant) begin
          state_next = EMPTY;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rst_tag     <= '0;
      rst_data    <= '0;
      jump_target <= '0;
      held_taken  <= 1'b0;
    end else if (rdy && load) begin
      rst_tag     <= ex_dest;
      rst_data    <= link;
      jump_target <= target;
      held_taken  <= taken;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (rdy && ex_en && ex_busy && is_branch) begin
      overflow <= 1'b1;
    end
  end

  // Statistics saturate so long runs never wrap back to small values.
  always_ff @(posedge clk) begin
    if (rst) begin
      branch_cnt <= '0;
      taken_cnt  <= '0;
    end else if (rdy && load) begin
      if (branch_cnt != {CNT_W{1'b1}}) begin
        branch_cnt <= branch_cnt + CNT_W'(1);
      end
      if (taken && (taken_cnt != {CNT_W{1'b1}})) begin
        taken_cnt <= taken_cnt + CNT_W'(1);
      end
    end
  end

  assign rst_en  = (state == FULL);
  assign jump_en = (state == FULL) && held_taken;

endmodule

// File: tb/tb_ex_branch.sv
// Self-checking bench for ex_branch: directed scenarios, random traffic and
// counter saturation, all compared against a behavioural model.
module tb_ex_branch;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int TAG_W  = 4;
  localparam int OP_W   = 6;
  localparam int CNT_W  = 16;

  localparam logic [OP_W-1:0] JAL  = 6'd1;
  localparam logic [OP_W-1:0] JALR = 6'd2;
  localparam logic [OP_W-1:0] BEQ  = 6'd3;
  localparam logic [OP_W-1:0] BNE  = 6'd4;
  localparam logic [OP_W-1:0] BLT  = 6'd5;
  localparam logic [OP_W-1:0] BGE  = 6'd6;
  localparam logic [OP_W-1:0] BLTU = 6'd7;
  localparam logic [OP_W-1:0] BGEU = 6'd8;

  logic              clk = 1'b0;
  logic              rst, rdy, clear, ex_en, cdb_grant;
  logic [DATA_W-1:0] ex_src1, ex_src2;
  logic [ADDR_W-1:0] ex_pc, ex_offset;
  logic [OP_W-1:0]   ex_op;
  logic [TAG_W-1:0]  ex_dest;
  logic              rst_en, jump_en, ex_busy, overflow;
  logic [TAG_W-1:0]  rst_tag;
  logic [DATA_W-1:0] rst_data;
  logic [ADDR_W-1:0] jump_target;
  logic [CNT_W-1:0]  branch_cnt, taken_cnt;

  int errors = 0;
  int checks = 0;

  // Reference model state
  bit          m_full = 0;
  bit          m_taken = 0;
  bit          m_ovf = 0;
  logic [3:0]  m_tag = '0;
  logic [31:0] m_data = '0;
  logic [31:0] m_target = '0;
  int          m_bcnt = 0;
  int          m_tcnt = 0;

  always #5 clk = ~clk;

  ex_branch #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .TAG_W(TAG_W), .OP_W(OP_W), .CNT_W(CNT_W),
    .OP_JAL(JAL), .OP_JALR(JALR), .OP_BEQ(BEQ), .OP_BNE(BNE),
    .OP_BLT(BLT), .OP_BGE(BGE), .OP_BLTU(BLTU), .OP_BGEU(BGEU)
  ) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
    .ex_en(ex_en), .ex_src1(ex_src1), .ex_src2(ex_src2), .ex_pc(ex_pc),
    .ex_op(ex_op), .ex_offset(ex_offset), .ex_dest(ex_dest),
    .cdb_grant(cdb_grant),
    .rst_en(rst_en), .rst_tag(rst_tag), .rst_data(rst_data),
    .jump_en(jump_en), .jump_target(jump_target), .ex_busy(ex_busy),
    .overflow(overflow), .branch_cnt(branch_cnt), .taken_cnt(taken_cnt)
  );

  function automatic bit is_br(input logic [OP_W-1:0] op);
    return (op >= JAL) && (op <= BGEU);
  endfunction

  function automatic bit ref_taken(input logic [OP_W-1:0] op, input logic [31:0] a, input logic [31:0] b);
    int sa = a;
    int sb = b;
    if (op == JAL || op == JALR) return 1;
    if (op == BEQ)  return a == b;
    if (op == BNE)  return a != b;
    if (op == BLT)  return sa < sb;
    if (op == BGE)  return sa >= sb;
    if (op == BLTU) return a < b;
    return a >= b;
  endfunction

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic check_output(input string tag);
    chk({tag, ".rst_en"},     64'(rst_en),     64'(m_full));
    chk({tag, ".jump_en"},    64'(jump_en),    64'(m_full && m_taken));
    chk({tag, ".overflow"},   64'(overflow),   64'(m_ovf));
    chk({tag, ".branch_cnt"}, 64'(branch_cnt), 64'(m_bcnt));
    chk({tag, ".taken_cnt"},  64'(taken_cnt),  64'(m_tcnt));
    if (m_full) begin
      chk({tag, ".rst_tag"},     64'(rst_tag),     64'(m_tag));
      chk({tag, ".rst_data"},    64'(rst_data),    64'(m_data));
      chk({tag, ".jump_target"}, 64'(jump_target), 64'(m_target));
    end
  endtask

  task automatic model_edge();
    bit busy, acc;
    if (rst) begin
      m_full = 0; m_taken = 0; m_ovf = 0;
      m_tag = '0; m_data = '0; m_target = '0;
      m_bcnt = 0; m_tcnt = 0;
    end else if (rdy) begin
      busy = m_full && !cdb_grant;
      acc  = ex_en && !busy && is_br(ex_op);
      if (ex_en && busy && is_br(ex_op)) m_ovf = 1;
      if (clear) begin
        m_full = 0;
      end else if (acc) begin
        m_full   = 1;
        m_tag    = ex_dest;
        m_taken  = ref_taken(ex_op, ex_src1, ex_src2);
        m_data   = (ex_op == JAL || ex_op == JALR) ? ex_pc + 32'd4 : 32'd0;
        m_target = (ex_op == JALR) ? ((ex_src1 + ex_offset) & ~32'd1) : ex_pc + ex_offset;
        if (m_bcnt < 16'hFFFF) m_bcnt++;
        if (m_taken && m_tcnt < 16'hFFFF) m_tcnt++;
      end else if (cdb_grant) begin
        m_full = 0;
      end
    end
  endtask

  // Drives one cycle of inputs, checks ex_busy before the edge and the
  // registered outputs after it.
  task automatic apply_stimulus(input string tag, input bit r, input bit y, input bit c,
                                input bit g, input bit e, input logic [OP_W-1:0] op,
                                input logic [31:0] s1, input logic [31:0] s2,
                                input logic [31:0] pc, input logic [31:0] off,
                                input logic [3:0] dest, input bit do_check);
    rst = r; rdy = y; clear = c; cdb_grant = g; ex_en = e; ex_op = op;
    ex_src1 = s1; ex_src2 = s2; ex_pc = pc; ex_offset = off; ex_dest = dest;
    #1;
    if (do_check && !r) chk({tag, ".ex_busy"}, 64'(ex_busy), 64'(m_full && !g));
    @(posedge clk);
    model_edge();
    @(negedge clk);
    if (do_check) check_output(tag);
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] s1, s2;
    apply_stimulus("reset", 1, 1, 0, 0, 0, BEQ, 0, 0, 0, 0, 0, 1);
    chk("reset.rst_tag",     64'(rst_tag),     64'h0);
    chk("reset.rst_data",    64'(rst_data),    64'h0);
    chk("reset.jump_target", 64'(jump_target), 64'h0);

    apply_stimulus("beq", 0, 1, 0, 0, 1, BEQ, 5, 5, 32'h100, 32'h20, 3, 1);
    chk("beq.jump_target.const", 64'(jump_target), 64'h120);
    chk("beq.rst_tag.const",     64'(rst_tag),     64'h3);
    apply_stimulus("blt",  0, 1, 0, 1, 1, BLT,  32'hFFFFFFFF, 1, 32'h40, 32'h8, 5, 1);
    chk("blt.jump_en.const", 64'(jump_en), 64'h1);
    apply_stimulus("bltu", 0, 1, 0, 1, 1, BLTU, 32'hFFFFFFFF, 1, 32'h40, 32'h8, 6, 1);
    chk("bltu.jump_en.const", 64'(jump_en), 64'h0);
    apply_stimulus("jalr", 0, 1, 0, 1, 1, JALR, 32'h1001, 0, 32'h200, 32'h4, 7, 1);
    chk("jalr.jump_target.const", 64'(jump_target), 64'h1004);
    chk("jalr.rst_data.const",    64'(rst_data),    64'h204);

    apply_stimulus("hold0", 0, 1, 0, 0, 0, BNE, 1, 2, 32'h300, 32'h10, 8, 1);
    apply_stimulus("hold1", 0, 1, 0, 0, 1, BNE, 1, 2, 32'h300, 32'h10, 8, 1);
    chk("hold1.overflow.const", 64'(overflow), 64'h1);
    apply_stimulus("hold2", 0, 1, 0, 0, 0, BNE, 1, 2, 32'h300, 32'h10, 8, 1);
    apply_stimulus("regrant", 0, 1, 0, 1, 1, JAL, 0, 0, 32'hFFFFFFFC, 32'h10, 9, 1);
    chk("regrant.rst_data.wrap", 64'(rst_data), 64'h0);

    apply_stimulus("clear", 0, 1, 1, 1, 1, BGE, 3, 3, 32'h500, 32'h4, 2, 1);
    apply_stimulus("badop", 0, 1, 0, 0, 1, 6'd0, 3, 3, 32'h500, 32'h4, 2, 1);
    apply_stimulus("bgeu",  0, 1, 0, 0, 1, BGEU, 7, 9, 32'h600, 32'hFFFFFFF0, 4, 1);
    apply_stimulus("rdylo", 0, 0, 0, 1, 1, BEQ, 1, 1, 32'h700, 32'h4, 1, 1);
    apply_stimulus("rstfull", 1, 1, 0, 0, 0, BEQ, 0, 0, 0, 0, 0, 1);

    for (int i = 0; i < 400; i++) begin
      s1 = $urandom();
      s2 = ($urandom_range(0, 3) == 0) ? s1 : $urandom();
      if ($urandom_range(0, 3) == 0) s1 = $urandom_range(0, 8);
      apply_stimulus("rand", $urandom_range(0, 49) == 0, $urandom_range(0, 6) != 0,
                     $urandom_range(0, 19) == 0, $urandom_range(0, 1) == 1,
                     $urandom_range(0, 9) < 6, OP_W'($urandom_range(0, 9)), s1, s2,
                     $urandom(), $urandom(), TAG_W'($urandom()), 1);
      if (rdy == 0) clear = 0;
    end

    apply_stimulus("satrst", 1, 1, 0, 0, 0, BEQ, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 65535; i++) begin
      apply_stimulus("sat", 0, 1, 0, 1, 1, JAL, 0, 0, i, 4, 1, 0);
    end
    check_output("sat_full");
    chk("sat_full.branch_cnt.const", 64'(branch_cnt), 64'hFFFF);
    apply_stimulus("sat_more", 0, 1, 0, 1, 1, BEQ, 1, 1, 0, 4, 1, 1);
    chk("sat_more.branch_cnt.const", 64'(branch_cnt), 64'hFFFF);
    apply_stimulus("final_rst", 1, 1, 0, 0, 0, BEQ, 0, 0, 0, 0, 0, 1);
    chk("final_rst.taken_cnt.const", 64'(taken_cnt), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
